// File: rtl/sumador_bk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sumador_bk_pkg
// Description : Shared ALU package: default operand width, operand type and
//               Brent-Kung tree depth helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sumador_bk_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef logic [WIDTH_DEFAULT-1:0] operand_t;

    // Prefix levels of a Brent-Kung tree: log2(w) up-sweep plus log2(w)-1 down-sweep.
    function automatic int bk_levels(input int w);
        return 2 * $clog2(w) - 1;
    endfunction

endpackage : sumador_bk_pkg
`default_nettype wire

// File: rtl/bk_prefix_cell.sv
`default_nettype none
// ============================================================================
// Module      : bk_prefix_cell
// Description : Prefix operator (G,P) o (G',P') = (G | P&G', P&P').
//               GRAY=1 drops the P output for groups that already reach bit 0,
//               whose P is never needed because G already holds the carry.
// Revision    : 1.0 - initial release
// ============================================================================
module bk_prefix_cell
    import sumador_bk_pkg::*;
#(
    parameter bit GRAY = 1'b0
) (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    assign g_out = g_hi | (p_hi & g_lo);

    generate
        if (GRAY) begin : g_gray
            // Group propagate is irrelevant once the group spans down to bit 0.
            logic unused_p_lo;
            assign unused_p_lo = p_lo;
            assign p_out       = 1'b0;
        end else begin : g_black
            assign p_out = p_hi & p_lo;
        end
    endgenerate

endmodule : bk_prefix_cell
`default_nettype wire

// File: rtl/sumador_bk.sv
`default_nettype none
// ============================================================================
// Module      : sumador_bk
// Description : Registered Brent-Kung parallel-prefix adder, sum = a + b + cin,
//               with carry-out. One output register stage, no enable.
// Revision    : 1.0 - initial release
// ============================================================================
module sumador_bk
    import sumador_bk_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LOG2 = $clog2(WIDTH);
    localparam int NLVL = bk_levels(WIDTH);

    // Per-bit generate/propagate.
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;

    // Group (G,P) per tree level; level 0 is the pre-processed input.
    logic [NLVL:0][WIDTH-1:0] grp_g;
    logic [NLVL:0][WIDTH-1:0] grp_p;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign g = a & b;
    assign p = a ^ b;

    // Carry-in folded into bit 0 so every group reaching bit 0 carries it.
    assign grp_g[0] = {g[WIDTH-1:1], g[0] | (p[0] & cin)};
    assign grp_p[0] = p;

    // Levels 1..LOG2 are the up-sweep (span 2^K ending at 2^K*m-1); the
    // remaining levels are the down-sweep, filling indices at half-span offsets.
    generate
        for (genvar lv = 1; lv <= NLVL; lv++) begin : g_lvl
            localparam bit UP   = (lv <= LOG2);
            localparam int K    = UP ? lv : (2 * LOG2 - lv);
            localparam int SPAN = 1 << K;
            localparam int HALF = 1 << (K - 1);
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                localparam bit IS_CELL = UP ? (((i + 1) % SPAN) == 0)
                                            : ((((i + 1) % SPAN) == HALF) && (i >= SPAN));
                localparam bit IS_GRAY = UP ? ((i + 1) == SPAN) : 1'b1;
                if (IS_CELL) begin : g_cell
                    bk_prefix_cell #(
                        .GRAY (IS_GRAY)
                    ) u_cell (
                        .g_hi  (grp_g[lv-1][i]),
                        .p_hi  (grp_p[lv-1][i]),
                        .g_lo  (grp_g[lv-1][i-HALF]),
                        .p_lo  (grp_p[lv-1][i-HALF]),
                        .g_out (grp_g[lv][i]),
                        .p_out (grp_p[lv][i])
                    );
                end else begin : g_pass
                    assign grp_g[lv][i] = grp_g[lv-1][i];
                    assign grp_p[lv][i] = grp_p[lv-1][i];
                end
            end
        end
    endgenerate

    // Final-level propagate is never needed; only G[i:0] forms the carries.
    logic unused_p_final;
    assign unused_p_final = ^grp_p[NLVL];

    // C[0] = cin, C[i] = G[i-1:0], cout = G[WIDTH-1:0].
    assign carry  = {grp_g[NLVL], cin};
    assign sum_d  = p ^ carry[WIDTH-1:0];
    assign cout_d = carry[WIDTH];

    // Output register: capture the result every edge, clear asynchronously on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : sumador_bk
`default_nettype wire

// File: tb/tb_sumador_bk.sv
`default_nettype none
// ============================================================================
// Module      : tb_sumador_bk
// Description : Scoreboard bench for sumador_bk, 8-bit and 4-bit instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sumador_bk;

    logic       clk;
    logic       rst;
    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] sum8;
    logic       cout8;
    logic [3:0] a4, b4;
    logic       c4;
    logic [3:0] sum4;
    logic       cout4;

    typedef struct {
        logic [8:0] e8;
        logic       chk8;
        logic [4:0] e4;
        logic       chk4;
    } exp_t;

    exp_t sb_q[$];
    logic drv_valid;
    int   n_vec;
    int   n_miss;

    sumador_bk #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .a    (a8),
        .b    (b8),
        .cin  (c8),
        .sum  (sum8),
        .cout (cout8)
    );

    sumador_bk #(.WIDTH(4)) dut4 (
        .clk  (clk),
        .rst  (rst),
        .a    (a4),
        .b    (b4),
        .cin  (c4),
        .sum  (sum4),
        .cout (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand set for the next rising edge and queue its expected result.
    task automatic apply(input logic [7:0] ia8, input logic [7:0] ib8, input logic ic8,
                         input logic [3:0] ia4, input logic [3:0] ib4, input logic ic4,
                         input logic [8:0] e8, input logic chk8,
                         input logic [4:0] e4, input logic chk4);
        exp_t e;
        a8 = ia8; b8 = ib8; c8 = ic8;
        a4 = ia4; b4 = ib4; c4 = ic4;
        e.e8 = e8; e.chk8 = chk8; e.e4 = e4; e.chk4 = chk4;
        sb_q.push_back(e);
        drv_valid = 1'b1;
        @(negedge clk);
    endtask

    // Drive both instances and derive expectations from integer addition.
    task automatic apply_gold(input logic [7:0] ia8, input logic [7:0] ib8, input logic ic8,
                              input logic [3:0] ia4, input logic [3:0] ib4, input logic ic4);
        logic [8:0] e8;
        logic [4:0] e4;
        e8 = {1'b0, ia8} + {1'b0, ib8} + {8'd0, ic8};
        e4 = {1'b0, ia4} + {1'b0, ib4} + {4'd0, ic4};
        apply(ia8, ib8, ic8, ia4, ib4, ic4, e8, 1'b1, e4, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if ({cout8, sum8} !== 9'h000) begin
            n_miss++;
            $display("FAIL %s_w8: got cout=%0b sum=%02h, want cout=0 sum=00", tag, cout8, sum8);
        end
        n_vec++;
        if ({cout4, sum4} !== 5'h00) begin
            n_miss++;
            $display("FAIL %s_w4: got cout=%0b sum=%01h, want cout=0 sum=0", tag, cout4, sum4);
        end
    endtask

    // Reset asynchronously between edges once the previous result is registered.
    task automatic mid_reset;
        drv_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("midrst_async");
        @(posedge clk);
        #1 check_zero("midrst_hold");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: an edge that took valid operands yields one result, checked on the falling edge.
    initial begin
        forever begin
            logic took;
            exp_t e;
            @(posedge clk);
            took = drv_valid && !rst;
            if (took) begin
                @(negedge clk);
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL sb_underflow: got result with empty queue, want queued entry");
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk8) begin
                        n_vec++;
                        if ({cout8, sum8} !== e.e8) begin
                            n_miss++;
                            $display("FAIL add_w8: got cout=%0b sum=%02h, want cout=%0b sum=%02h",
                                     cout8, sum8, e.e8[8], e.e8[7:0]);
                        end
                    end
                    if (e.chk4) begin
                        n_vec++;
                        if ({cout4, sum4} !== e.e4) begin
                            n_miss++;
                            $display("FAIL add_w4: got cout=%0b sum=%01h, want cout=%0b sum=%01h",
                                     cout4, sum4, e.e4[4], e.e4[3:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion within time bound, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        drv_valid = 1'b0;
        rst       = 1'b1;
        a8 = 8'hDA; b8 = 8'h55; c8 = 1'b0;
        a4 = 4'hD;  b4 = 4'h5;  c4 = 1'b0;
        #1 check_zero("reset");

        // Release reset between edges; the first edge loads the held operands.
        @(negedge clk);
        rst = 1'b0;
        apply(8'hDA, 8'h55, 1'b0, 4'hD, 4'h5, 1'b0, 9'h12F, 1'b1, 5'h12, 1'b1);
        apply(8'h7A, 8'h55, 1'b0, 4'h7, 4'h5, 1'b0, 9'h0CF, 1'b1, 5'h0C, 1'b1);
        apply(8'hFF, 8'h80, 1'b0, 4'hF, 4'h4, 1'b0, 9'h17F, 1'b1, 5'h13, 1'b1);
        // Carry ripple across the whole tree.
        apply(8'hFF, 8'h00, 1'b1, 4'h0, 4'h0, 1'b0, 9'h100, 1'b1, 5'h00, 1'b0);
        apply(8'h7F, 8'h00, 1'b1, 4'h0, 4'h0, 1'b0, 9'h080, 1'b1, 5'h00, 1'b0);
        // Extremes.
        apply(8'h00, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 9'h000, 1'b1, 5'h00, 1'b1);
        apply(8'hFF, 8'hFF, 1'b1, 4'hF, 4'hF, 1'b1, 9'h1FF, 1'b1, 5'h1F, 1'b1);

        mid_reset();

        // WIDTH=4 exhaustive, WIDTH=8 fed pseudo-random operands alongside.
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int k = 0; k < 2; k++)
                    apply_gold(8'($urandom), 8'($urandom), 1'($urandom),
                               4'(i), 4'(j), 1'(k));

        apply(8'hFF, 8'hFF, 1'b1, 4'hF, 4'hF, 1'b1, 9'h1FF, 1'b1, 5'h1F, 1'b1);
        mid_reset();

        // WIDTH=8 strided sweep over a and b, both carry-in values.
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 20; j++)
                for (int k = 0; k < 2; k++)
                    apply_gold(8'(i * 17), 8'(j * 13), 1'(k),
                               4'(i), 4'(j), 1'(k));

        // Random back-to-back vectors.
        for (int n = 0; n < 800; n++)
            apply_gold(8'($urandom), 8'($urandom), 1'($urandom),
                       4'($urandom), 4'($urandom), 1'($urandom));

        drv_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL sb_drain: got %0d pending entries, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_sumador_bk
`default_nettype wire
